// File: rtl/fetch_miss_ctrl_pkg.sv
// Shared types for the fetch miss sequencer: FSM state encoding and line-select codes.
package op_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_ctrl_state_e;

  localparam logic LINE_SEL_L0  = 1'b0;
  localparam logic LINE_SEL_L1I = 1'b1;

endpackage

// File: rtl/fetch_miss_ctrl_if.sv
// L1I request/response handshake bundle between the fetch miss sequencer and the L1I.
interface fetch_miss_ctrl_if #(
  parameter int ADDR_WIDTH = 64
);

  logic                  l1i_req_valid_out;
  logic [ADDR_WIDTH-1:0] l1i_req_addr_out;
  logic                  l1i_req_ready_in;
  logic                  l1i_resp_valid_in;
  logic                  l1i_resp_ready_out;

  modport master (
    output l1i_req_valid_out,
    output l1i_req_addr_out,
    output l1i_resp_ready_out,
    input  l1i_req_ready_in,
    input  l1i_resp_valid_in
  );

  modport slave (
    input  l1i_req_valid_out,
    input  l1i_req_addr_out,
    input  l1i_resp_ready_out,
    output l1i_req_ready_in,
    output l1i_resp_valid_in
  );

endinterface

// File: rtl/fetch_miss_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             inc_in,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_in && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/fetch_miss_ctrl.sv
// Fetch miss sequencer: issues L0 hits immediately, otherwise runs one L1I line fetch
// and drops responses that a flush has made stale.
module fetch_miss_ctrl
  import op_pkg::*;
#(
  parameter int ADDR_WIDTH       = 64,
  parameter int CACHE_LINE_WIDTH = 64,
  parameter int COUNTER_WIDTH    = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     flush_in,
  input  logic                     pc_valid_in,
  input  logic [ADDR_WIDTH-1:0]    pc_in,
  input  logic                     l0_hit_in,
  output logic                     pc_ready_out,
  input  logic                     decode_ready_in,
  fetch_miss_ctrl_if.master        l1i,
  output logic                     issue_valid_out,
  output logic                     line_sel_out,
  output logic [ADDR_WIDTH-1:0]    issue_pc_out,
  output logic [COUNTER_WIDTH-1:0] miss_count_out,
  output logic [COUNTER_WIDTH-1:0] stall_count_out
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~(ADDR_WIDTH'(CACHE_LINE_WIDTH) - 1'b1);

  fetch_ctrl_state_e     state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  logic                  pc_take;
  logic                  resp_take;
  logic                  miss_inc;
  logic                  stall_inc;
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pc_ready_out    = 1'b0;
    pc_take         = 1'b0;
    resp_take       = 1'b0;
    req_valid       = 1'b0;
    req_addr        = '0;
    resp_ready      = 1'b0;
    issue_valid_out = 1'b0;
    line_sel_out    = LINE_SEL_L0;
    issue_pc_out    = '0;
    miss_inc        = 1'b0;

    if (!rst_in) begin
      unique case (state_q)
        IDLE: begin
          pc_ready_out = decode_ready_in & ~flush_in;
          pc_take      = pc_valid_in & pc_ready_out;
          if (pc_take && l0_hit_in) begin
            issue_valid_out = 1'b1;
            line_sel_out    = LINE_SEL_L0;
            issue_pc_out    = pc_in;
          end else if (pc_take) begin
            pc_d    = pc_in;
            state_d = REQ;
          end
        end
        REQ: begin
          req_valid = 1'b1;
          req_addr  = pc_q & LINE_MASK;
          if (l1i.l1i_req_ready_in) begin
            miss_inc = 1'b1;
            state_d  = flush_in ? DRAIN : WAIT;
          end else if (flush_in) begin
            state_d = IDLE;
          end
        end
        WAIT: begin
          resp_ready = decode_ready_in;
          resp_take  = l1i.l1i_resp_valid_in & decode_ready_in;
          if (resp_take) begin
            state_d = IDLE;
            if (!flush_in) begin
              issue_valid_out = 1'b1;
              line_sel_out    = LINE_SEL_L1I;
              issue_pc_out    = pc_q;
            end
          end else if (flush_in) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          // The only outstanding line is consumed here, so a flush in the same cycle
          // must not hold DRAIN or nothing would ever release it.
          resp_ready = 1'b1;
          if (l1i.l1i_resp_valid_in) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign stall_inc = (state_q != IDLE);

  assign l1i.l1i_req_valid_out  = req_valid;
  assign l1i.l1i_req_addr_out   = req_addr;
  assign l1i.l1i_resp_ready_out = resp_ready;

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_miss_cnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .inc_in    (miss_inc),
    .count_out (miss_count_out)
  );

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .inc_in    (stall_inc),
    .count_out (stall_count_out)
  );

endmodule

// File: tb/tb_fetch_miss_ctrl.sv
// Self-checking bench for fetch_miss_ctrl: directed scenarios plus random traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_fetch_miss_ctrl;

  localparam int AW = 64;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_in, flush_in, pc_valid_in, l0_hit_in, decode_ready_in;
  logic          req_ready, resp_valid;
  logic [AW-1:0] pc_in;

  logic          pc_ready_a, issue_valid_a, line_sel_a;
  logic [AW-1:0] issue_pc_a;
  logic [31:0]   miss_a, stall_a;
  logic          pc_ready_b, issue_valid_b, line_sel_b;
  logic [AW-1:0] issue_pc_b;
  logic [3:0]    miss_b, stall_b;

  fetch_miss_ctrl_if #(.ADDR_WIDTH(AW)) l1i_a ();
  fetch_miss_ctrl_if #(.ADDR_WIDTH(AW)) l1i_b ();

  assign l1i_a.l1i_req_ready_in  = req_ready;
  assign l1i_a.l1i_resp_valid_in = resp_valid;
  assign l1i_b.l1i_req_ready_in  = req_ready;
  assign l1i_b.l1i_resp_valid_in = resp_valid;

  fetch_miss_ctrl #(.ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(64), .COUNTER_WIDTH(32)) u_dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .pc_valid_in     (pc_valid_in),
    .pc_in           (pc_in),
    .l0_hit_in       (l0_hit_in),
    .pc_ready_out    (pc_ready_a),
    .decode_ready_in (decode_ready_in),
    .l1i             (l1i_a),
    .issue_valid_out (issue_valid_a),
    .line_sel_out    (line_sel_a),
    .issue_pc_out    (issue_pc_a),
    .miss_count_out  (miss_a),
    .stall_count_out (stall_a)
  );

  fetch_miss_ctrl #(.ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(64), .COUNTER_WIDTH(4)) u_sat (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .pc_valid_in     (pc_valid_in),
    .pc_in           (pc_in),
    .l0_hit_in       (l0_hit_in),
    .pc_ready_out    (pc_ready_b),
    .decode_ready_in (decode_ready_in),
    .l1i             (l1i_b),
    .issue_valid_out (issue_valid_b),
    .line_sel_out    (line_sel_b),
    .issue_pc_out    (issue_pc_b),
    .miss_count_out  (miss_b),
    .stall_count_out (stall_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a miss is "requested" until the L1I takes it, then "owed" until a
  // line comes back; a flush while owed marks that line as to be dropped.
  bit          m_req, m_resp, m_drop;
  logic [63:0] m_pc;
  longint      m_miss, m_stall;

  function automatic logic [63:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  task automatic check_outputs();
    bit          idle, e_pcr, e_hit, e_l1, e_reqv, e_respr;
    logic [63:0] e_addr, e_ipc;
    idle    = !m_req && !m_resp;
    e_pcr   = !rst_in && idle && decode_ready_in && !flush_in;
    e_hit   = e_pcr && pc_valid_in && l0_hit_in;
    e_l1    = !rst_in && m_resp && !m_drop && resp_valid && decode_ready_in && !flush_in;
    e_reqv  = !rst_in && m_req;
    e_addr  = e_reqv ? (m_pc - (m_pc % 64)) : 64'd0;
    e_respr = !rst_in && m_resp && (m_drop || decode_ready_in);
    e_ipc   = e_hit ? pc_in : (e_l1 ? m_pc : 64'd0);
    check("pc_ready",    64'(pc_ready_a), 64'(e_pcr));
    check("req_valid",   64'(l1i_a.l1i_req_valid_out), 64'(e_reqv));
    check("req_addr",    l1i_a.l1i_req_addr_out, e_addr);
    check("resp_ready",  64'(l1i_a.l1i_resp_ready_out), 64'(e_respr));
    check("issue_valid", 64'(issue_valid_a), 64'(e_hit || e_l1));
    check("line_sel",    64'(line_sel_a), 64'(e_l1));
    check("issue_pc",    issue_pc_a, e_ipc);
    check("miss_cnt",    64'(miss_a), sat(m_miss, 32));
    check("stall_cnt",   64'(stall_a), sat(m_stall, 32));
    check("sat_issue",   64'(issue_valid_b), 64'(e_hit || e_l1));
    check("sat_miss",    64'(miss_b), sat(m_miss, 4));
    check("sat_stall",   64'(stall_b), sat(m_stall, 4));
  endtask

  task automatic model_update();
    bit idle;
    idle = !m_req && !m_resp;
    if (rst_in) begin
      m_req = 0; m_resp = 0; m_drop = 0; m_pc = '0; m_miss = 0; m_stall = 0;
    end else begin
      if (!idle) m_stall++;
      if (idle) begin
        if (pc_valid_in && decode_ready_in && !flush_in && !l0_hit_in) begin
          m_req = 1;
          m_pc  = pc_in;
        end
      end else if (m_req) begin
        if (req_ready) begin
          m_miss++;
          m_req  = 0;
          m_resp = 1;
          m_drop = flush_in;
        end else if (flush_in) begin
          m_req = 0;
        end
      end else if (!m_drop) begin
        if (resp_valid && decode_ready_in) m_resp = 0;
        else if (flush_in) m_drop = 1;
      end else if (resp_valid) begin
        m_resp = 0;
        m_drop = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    check_outputs();
    model_update();
    @(posedge clk_in);
    #1;
  endtask

  task automatic quiet_inputs();
    rst_in = 0; flush_in = 0; pc_valid_in = 0; l0_hit_in = 0;
    decode_ready_in = 1; req_ready = 0; resp_valid = 0; pc_in = '0;
  endtask

  task automatic start_miss(input logic [63:0] pc);
    pc_in = pc; pc_valid_in = 1; l0_hit_in = 0;
    step();
    pc_valid_in = 0;
  endtask

  initial begin
    m_req = 0; m_resp = 0; m_drop = 0; m_pc = '0; m_miss = 0; m_stall = 0;
    quiet_inputs();
    rst_in = 1;
    @(posedge clk_in);
    #1;
    repeat (2) step();
    rst_in = 0;

    // Hit: same-cycle issue from the L0 line
    pc_in = 64'h1000; pc_valid_in = 1; l0_hit_in = 1;
    #1;
    check("hit_issue", 64'(issue_valid_a), 64'd1);
    check("hit_pc", issue_pc_a, 64'h1000);
    step();
    pc_valid_in = 0; l0_hit_in = 0;

    // Miss round trip: 4 cycles in REQ, 5 in WAIT
    start_miss(64'h2048);
    #1;
    check("miss_addr", l1i_a.l1i_req_addr_out, 64'h2040);
    repeat (3) step();
    req_ready = 1;
    step();
    req_ready = 0;
    check("miss_cnt1", 64'(miss_a), 64'd1);
    repeat (4) step();
    resp_valid = 1;
    #1;
    check("miss_issue", 64'(issue_valid_a), 64'd1);
    check("miss_sel", 64'(line_sel_a), 64'd1);
    check("miss_pc", issue_pc_a, 64'h2048);
    step();
    resp_valid = 0;
    check("stall9", 64'(stall_a), 64'd9);

    // Decode backpressure while a line is waiting
    start_miss(64'h3010);
    req_ready = 1; step(); req_ready = 0;
    resp_valid = 1; decode_ready_in = 0;
    #1;
    check("bp_ready", 64'(l1i_a.l1i_resp_ready_out), 64'd0);
    repeat (2) step();
    decode_ready_in = 1;
    #1;
    check("bp_issue", 64'(issue_valid_a), 64'd1);
    step();
    resp_valid = 0;
    step();

    // Flush while waiting: the late line is drained, never issued
    start_miss(64'h4000);
    req_ready = 1; step(); req_ready = 0;
    flush_in = 1; step(); flush_in = 0;
    check("drain_pcr", 64'(pc_ready_a), 64'd0);
    repeat (3) step();
    resp_valid = 1;
    #1;
    check("drain_noiss", 64'(issue_valid_a), 64'd0);
    step();
    resp_valid = 0;
    pc_in = 64'h5000; pc_valid_in = 1; l0_hit_in = 1;
    #1;
    check("post_hit", 64'(issue_valid_a), 64'd1);
    step();
    pc_valid_in = 0; l0_hit_in = 0;

    // Flush in REQ, accepted and not accepted
    start_miss(64'h6000);
    flush_in = 1; req_ready = 1; step(); flush_in = 0; req_ready = 0;
    resp_valid = 1; step(); resp_valid = 0;
    start_miss(64'h7000);
    flush_in = 1; step(); flush_in = 0;
    check("withdraw", 64'(l1i_a.l1i_req_valid_out), 64'd0);

    // Long stall drives the 4-bit counters to saturation
    start_miss(64'h8000);
    repeat (20) step();
    check("sat_hold", 64'(stall_b), 64'hF);
    req_ready = 1; step(); req_ready = 0;
    resp_valid = 1; step(); resp_valid = 0;

    for (int i = 0; i < 2000; i++) begin
      rst_in          = ($urandom_range(0, 99) == 0);
      flush_in        = ($urandom_range(0, 9) == 0);
      pc_valid_in     = $urandom_range(0, 1);
      l0_hit_in       = $urandom_range(0, 1);
      decode_ready_in = ($urandom_range(0, 3) != 0);
      req_ready       = ($urandom_range(0, 2) == 0);
      resp_valid      = ($urandom_range(0, 2) == 0);
      pc_in           = {$urandom, $urandom};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
